sram_array_ctrl: RTL and testbench



---
 rtl/sram_array_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sram_array_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_array_ctrl.sv
// sram_array_ctrl
//   Synchronous single-port SRAM array with a built-in controller. After reset,
//   or when clr is sampled while idle, a clear sweep writes zero to every word,
//   one word per cycle. Requests are accepted only while ready=1. Reads are
//   registered and return data one cycle after the request, marked by a
//   single-cycle data_valid strobe.
//
//   Optional build macro: SRAM_ARRAY_PARITY_EN
//     Each word stores one extra parity bit, and reads report parity_err.
//     With the macro undefined there is no parity storage, parity_err is
//     always 0 and inj_par_err is ignored.
//
//   Ports:
//     clk          system clock; all state changes on the rising edge
//     rst          asynchronous active-high reset
//     Row_select   access request; accepted only when ready=1
//     Write_enable 1 = write, 0 = read; sampled together with Row_select
//     addr         word address (ADDR_WIDTH bits)
//     data_in      write data (DATA_WIDTH bits)
//     clr          starts a clear sweep when sampled while idle
//     inj_par_err  inverts the stored parity bit on this write (parity build only)
//     data_out     registered read data; holds the last value read
//     data_valid   one-cycle strobe; data_out was updated this cycle
//     ready        controller is accepting requests
//     init_done    whole array cleared since the last reset or clr
//     parity_err   parity mismatch on the read being presented
module sram_array_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Row_select,
    input  logic                  Write_enable,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clr,
    input  logic                  inj_par_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  ready,
    output logic                  init_done,
    output logic                  parity_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Even parity over one data word.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] clr_cnt_r;
    logic [ADDR_WIDTH-1:0] clr_cnt_nxt_s;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic                  accept_s;
    logic                  rd_accept_s;
    logic                  wr_accept_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic                  rd_par_err_s;

    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  data_valid_r;
    logic                  ready_r;
    logic                  init_done_r;
    logic                  parity_err_r;

    // State register and clear-sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // Next-state logic: the sweep leaves CLEAR on the cycle that writes the last
    // word; the counter then wraps to 0 by itself. clr only matters when idle.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                clr_cnt_nxt_s = clr_cnt_r + ADDR_WIDTH'(1'b1);
                if (clr_cnt_r == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_nxt_s   = ST_IDLE;
                    clr_cnt_nxt_s = clr_cnt_r;
                end
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Request acceptance: clr has priority and drops a same-cycle request.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && Row_select && !clr;
        wr_accept_s = accept_s && Write_enable;
        rd_accept_s = accept_s && !Write_enable;
    end

    // The single memory port is driven by the sweep in CLEAR, and by the
    // requester otherwise.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = addr;
        mem_wdata_s = data_in;
        if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_cnt_r;
            mem_wdata_s = {DATA_WIDTH{1'b0}};
        end else begin
            mem_we_s    = wr_accept_s;
            mem_addr_s  = addr;
            mem_wdata_s = data_in;
        end
    end

    // Storage array. It has no reset; its contents are defined by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_wdata_s;
        end
    end

`ifdef SRAM_ARRAY_PARITY_EN
    logic par_mem_r [DEPTH];
    logic mem_wpar_s;

    // Parity to store: 0 during the sweep (consistent with zero data),
    // otherwise the data parity, optionally inverted to inject an error.
    always_comb begin
        mem_wpar_s = 1'b0;
        if (state_r == ST_CLEAR) begin
            mem_wpar_s = 1'b0;
        end else begin
            mem_wpar_s = calc_parity(data_in) ^ inj_par_err;
        end
    end

    // Parity bit storage, written alongside the data word.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            par_mem_r[mem_addr_s] <= mem_wpar_s;
        end
    end

    assign rd_par_err_s = calc_parity(mem_r[addr]) ^ par_mem_r[addr];
`else
    logic unused_inj_par_err_s;
    assign unused_inj_par_err_s = inj_par_err;
    assign rd_par_err_s         = 1'b0;
`endif

    // Registered outputs. ready/init_done follow the next state, so they match
    // the state register. data_out holds its value unless a read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_r   <= {DATA_WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            ready_r      <= 1'b0;
            init_done_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            data_valid_r <= rd_accept_s;
            parity_err_r <= rd_accept_s ? rd_par_err_s : 1'b0;
            ready_r      <= (state_nxt_s == ST_IDLE);
            init_done_r  <= (state_nxt_s == ST_IDLE);
            if (rd_accept_s) begin
                data_out_r <= mem_r[addr];
            end
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign ready      = ready_r;
    assign init_done  = init_done_r;
    assign parity_err = parity_err_r;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Self-checking bench for sram_array_ctrl (DATA_WIDTH=8, ADDR_WIDTH=4).
// A scoreboard queue holds {parity_err, data} for every read issued. These
// entries are popped when data_valid is expected, one cycle after the request.
module tb_sram_array_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Row_select = 1'b0;
    logic       Write_enable = 1'b0;
    logic [3:0] addr = 4'd0;
    logic [7:0] data_in = 8'd0;
    logic       clr = 1'b0;
    logic       inj_par_err = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       ready;
    logic       init_done;
    logic       parity_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m [16];
    logic       par_m [16];
    logic [8:0] sb_q [$];
    logic [7:0] last_data = 8'd0;
    logic       pend_rd = 1'b0;
    int         n;

    sram_array_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .Row_select(Row_select), .Write_enable(Write_enable),
        .addr(addr), .data_in(data_in), .clr(clr), .inj_par_err(inj_par_err),
        .data_out(data_out), .data_valid(data_valid), .ready(ready),
        .init_done(init_done), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: sample #1 after the edge and compare against the scoreboard.
    task automatic step();
        logic       exp_v;
        logic [8:0] ent;
        exp_v   = pend_rd;
        pend_rd = 1'b0;
        @(posedge clk);
        #1;
        check_eq("data_valid", {31'd0, data_valid}, {31'd0, exp_v});
        if (exp_v) begin
            ent       = sb_q.pop_front();
            last_data = ent[7:0];
            check_eq("parity_err", {31'd0, parity_err}, {31'd0, ent[8]});
        end else begin
            check_eq("parity_err_idle", {31'd0, parity_err}, 32'd0);
        end
        check_eq("data_out", {24'd0, data_out}, {24'd0, last_data});
    endtask

    task automatic idle_inputs();
        Row_select   = 1'b0;
        Write_enable = 1'b0;
        clr          = 1'b0;
        inj_par_err  = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic inj);
        Row_select   = 1'b1;
        Write_enable = 1'b1;
        addr         = a;
        data_in      = d;
        inj_par_err  = inj;
        mem_m[a]     = d;
        par_m[a]     = inj;
        step();
        idle_inputs();
    endtask

    task automatic do_read(input logic [3:0] a);
        logic e;
`ifdef SRAM_ARRAY_PARITY_EN
        e = par_m[a];
`else
        e = 1'b0;
`endif
        Row_select   = 1'b1;
        Write_enable = 1'b0;
        addr         = a;
        sb_q.push_back({e, mem_m[a]});
        pend_rd = 1'b1;
        step();
        idle_inputs();
    endtask

    // Count edges until ready rises (bounded); optionally pulse clr at edge clr_at.
    task automatic wait_ready(input int clr_at);
        int cnt;
        cnt = 0;
        do begin
            clr = (cnt == clr_at);
            step();
            clr = 1'b0;
            cnt++;
            if (ready !== 1'b1) check_eq("init_done_low", {31'd0, init_done}, 32'd0);
        end while (ready !== 1'b1 && cnt < 40);
        check_eq("sweep_len", cnt, 32'd16);
        check_eq("init_done", {31'd0, init_done}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = 8'd0;
            par_m[i] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_dout"}, {24'd0, data_out}, 32'd0);
        check_eq({tag, "_dv"}, {31'd0, data_valid}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, ready}, 32'd0);
        check_eq({tag, "_init"}, {31'd0, init_done}, 32'd0);
        check_eq({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
    endtask

    task automatic assert_rst();
        rst       = 1'b1;
        pend_rd   = 1'b0;
        last_data = 8'd0;
        sb_q.delete();
    endtask

    initial begin
        // Power-on reset and first sweep.
        #1 rst = 1'b1;
        #1 check_reset_outputs("por");
        step();
        step();
        rst = 1'b0;
        wait_ready(-1);
        for (int i = 0; i < 16; i++) do_read(4'(i));
        step();

        // Write then read the same address on the next cycle.
        do_write(4'd3, 8'hA5, 1'b0);
        do_read(4'd3);
        step();
        step();

        // Back-to-back reads.
        do_write(4'd0, 8'h11, 1'b0);
        do_write(4'd1, 8'h22, 1'b0);
        do_write(4'd2, 8'h33, 1'b0);
        do_read(4'd2);
        do_read(4'd1);
        do_read(4'd0);
        step();

        // clr beats a same-cycle read; a second clr mid-sweep does not restart it.
        do_write(4'd5, 8'hFF, 1'b0);
        clr          = 1'b1;
        Row_select   = 1'b1;
        Write_enable = 1'b0;
        addr         = 4'd5;
        step();
        idle_inputs();
        check_eq("ready_after_clr", {31'd0, ready}, 32'd0);
        wait_ready(5);
        do_read(4'd5);
        step();

        // Parity injection.
        do_write(4'd9, 8'h0F, 1'b1);
        do_write(4'd8, 8'h0F, 1'b0);
        do_read(4'd9);
        do_read(4'd8);
        step();

        // Reset while a read strobe is being presented.
        do_write(4'd3, 8'h5A, 1'b0);
        do_read(4'd3);
        assert_rst();
        #1 check_reset_outputs("rst_rd");
        step();
        rst = 1'b0;

        // Reset again in the middle of the sweep.
        for (int i = 0; i < 7; i++) step();
        assert_rst();
        #1 check_reset_outputs("rst_sweep");
        step();
        rst = 1'b0;
        wait_ready(-1);
        do_read(4'd3);
        do_read(4'd9);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
